systolic_feeder: RTL and testbench

- Upstream stage of the N×N systolic array multiplier. Accepts one int8 matrix pair A (N×N) and B (N×N) through a valid/ready handshake.
- Builds the diagonally skewed row and column streams and shifts them into the array one slot per cycle. Drives the array's process enable and reports completion.
- The array consumes only slot 0 of each lane per cycle, so this block owns all skew, zero-padding and sequencing.

---
 rtl/systolic_pkg.sv | 11 +
 rtl/skew_lane.sv | 19 +
 rtl/systolic_feeder.sv | 65 ++++++
 tb/tb_systolic_feeder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared element/lane types, feeder states and stream length
package systolic_pkg;
  localparam int ARRAY_N = 4;
  typedef logic signed [7:0] int8_t;
  typedef int8_t [ARRAY_N-1:0][ARRAY_N-1:0] matrix_t;
  typedef int8_t [2*ARRAY_N-2:0] lane_t;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction
endpackage

// File: rtl/skew_lane.sv
// skew_lane: parallel-load register that shifts one slot toward slot 0 per enable
module skew_lane
  import systolic_pkg::*;
#(
  parameter int S = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  int8_t [S-1:0]   din,
  output int8_t [S-1:0]   q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {8'h00, q[S-1:1]};
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A rows and B columns into lanes and streams them into the array
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                              i_clk,
  input  logic                              i_arst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic signed [N-1:0][N-1:0][7:0]   i_a,
  input  logic signed [N-1:0][N-1:0][7:0]   i_b,
  output logic signed [N-1:0][2*N-2:0][7:0] o_row,
  output logic signed [N-1:0][2*N-2:0][7:0] o_col,
  output logic                              o_doProcess,
  output logic                              o_busy,
  output logic                              o_done
);
  localparam int L = stream_len(N);
  localparam int CW = $clog2(L);
  localparam int S = 2 * N - 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic load, shift;
  logic [N-1:0][S-1:0][7:0] row_d, col_d;
  // Lane i holds its matrix vector starting at slot i, which produces the diagonal skew
  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar k = 0; k < S; k++) begin : g_slot
      if (k >= i && k < i + N) begin : g_data
        assign row_d[i][k] = i_a[i][k-i];
        assign col_d[i][k] = i_b[k-i][i];
      end else begin : g_pad
        assign row_d[i][k] = '0;
        assign col_d[i][k] = '0;
      end
    end
    skew_lane #(.S(S)) u_row (
      .clk(i_clk), .rst(i_arst), .load(load), .shift(shift), .din(row_d[i]), .q(o_row[i])
    );
    skew_lane #(.S(S)) u_col (
      .clk(i_clk), .rst(i_arst), .load(load), .shift(shift), .din(col_d[i]), .q(o_col[i])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= load ? '0 : shift ? cnt + 1'b1 : cnt;
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && i_valid) state_nx = STREAM;
    else if (state == STREAM && cnt == CW'(L - 1)) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  assign load        = state == IDLE && i_valid && !i_arst;
  assign shift       = state == STREAM;
  assign o_ready     = state == IDLE && !i_arst;
  assign o_doProcess = shift;
  assign o_busy      = shift;
  assign o_done      = state == DONE;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench; stimulus queues expected lanes, monitor compares per stream cycle
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int S = 2 * N - 1;
  localparam int L = 3 * N - 2;
  typedef logic signed [N-1:0][N-1:0][7:0] mat_t;
  typedef logic signed [N-1:0][S-1:0][7:0] lanes_t;
  typedef struct {
    lanes_t row;
    lanes_t col;
  } exp_t;

  logic clk = 1'b0;
  logic arst, valid, ready, do_process, busy, done;
  mat_t a, b;
  lanes_t row, col;
  exp_t q[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0, done_seen = 0;
  logic [7:0] s0_r0, s0_r1, s0_c0, s3_r3;
  logic s0_busy;

  systolic_feeder #(.N(N)) dut (
    .i_clk(clk), .i_arst(arst), .i_valid(valid), .o_ready(ready),
    .i_a(a), .i_b(b), .o_row(row), .o_col(col),
    .o_doProcess(do_process), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected lanes c cycles after load: slot k shows what was loaded into slot k+c
  function automatic exp_t model(input mat_t ma, input mat_t mb, input int c);
    exp_t r;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < S; k++) begin
        int s = k + c;
        r.row[i][k] = 8'h00;
        r.col[i][k] = 8'h00;
        if (s >= i && s < i + N) begin
          r.row[i][k] = ma[i][s-i];
          r.col[i][k] = mb[s-i][i];
        end
      end
    return r;
  endfunction

  task automatic push(input mat_t ma, input mat_t mb);
    for (int c = 0; c < L; c++) q.push_back(model(ma, mb, c));
  endtask

  // Called at a falling edge; returns just after the accepting rising edge
  task automatic send(input mat_t ma, input mat_t mb, input bit hold, input mat_t a_after);
    a = ma;
    b = mb;
    valid = 1'b1;
    for (int w = 0; w < 50 && !ready; w++) @(negedge clk);
    chk("handshake_ready", int'(ready), 1);
    push(ma, mb);
    @(posedge clk);
    #1;
    a = a_after;
    if (!hold) valid = 1'b0;
  endtask

  task automatic run_stream(output int cyc);
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        s0_r0 = row[0][0];
        s0_r1 = row[1][0];
        s0_c0 = col[0][0];
        s0_busy = busy;
      end
      if (cyc == 3) s3_r3 = row[3][0];
      if (done) break;
    end
  endtask

  always @(negedge clk) begin
    if (done) done_seen++;
    if (do_process) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_stream: do_process=1 with no expected data");
      end else begin
        mon_e = q.pop_front();
        if (row !== mon_e.row || col !== mon_e.col) begin
          miscompares++;
          $display("FAIL lanes: row=%h exp=%h col=%h exp=%h", row, mon_e.row, col, mon_e.col);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mat_t ma, mid, mneg, mpos, m2, m3;
    int cyc, d0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k]   = 8'(4 * i + k + 1);
        mid[i][k]  = (i == k) ? 8'sd1 : 8'sd0;
        mneg[i][k] = 8'h80;
        mpos[i][k] = 8'h7f;
        m2[i][k]   = 8'(16 * i - 3 * k - 7);
        m3[i][k]   = ~8'(4 * i + k + 1);
      end
    arst = 1'b1;
    valid = 1'b0;
    a = '0;
    b = '0;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", int'(ready), 0);
    end
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_row_zero", int'(row == '0), 1);
    chk("rst_col_zero", int'(col == '0), 1);
    chk("rst_do_process", int'(do_process), 0);
    chk("rst_done", int'(done), 0);

    send(ma, mid, 1'b0, ma);
    run_stream(cyc);
    chk("c0_row0", int'(s0_r0), 1);
    chk("c0_row1", int'(s0_r1), 0);
    chk("c0_col0", int'(s0_c0), 1);
    chk("c0_busy", int'(s0_busy), 1);
    chk("c3_row3", int'(s3_r3), 13);
    chk("done_cycle", cyc, 10);

    send(mneg, mpos, 1'b0, mneg);
    run_stream(cyc);
    chk("neg_row0", int'(s0_r0), 'h80);
    chk("pos_col0", int'(s0_c0), 'h7f);
    chk("ext_done_cycle", cyc, 10);

    d0 = done_seen;
    send(ma, mid, 1'b1, m2);
    b = mneg;
    run_stream(cyc);
    chk("held_done_cycle", cyc, 10);
    chk("held_ready_on_done", int'(ready), 0);
    @(negedge clk);
    chk("held_ready_after_done", int'(ready), 1);
    push(m2, mneg);
    @(posedge clk);
    #1;
    a = m3;
    valid = 1'b0;
    run_stream(cyc);
    chk("second_done_cycle", cyc, 10);
    chk("held_done_pulses", done_seen - d0, 2);

    send(m2, ma, 1'b0, m3);
    for (int c = 0; c <= 5; c++) @(negedge clk);
    d0 = done_seen;
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_do_process", int'(do_process), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_row_zero", int'(row == '0), 1);
    chk("mid_rst_col_zero", int'(col == '0), 1);
    repeat (15) @(negedge clk);
    chk("mid_rst_no_done", done_seen - d0, 0);

    send(m3, m2, 1'b0, ma);
    run_stream(cyc);
    chk("recover_done_cycle", cyc, 10);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
